// File: rtl/hamming_pkg.sv
// Shared (7,4) Hamming definitions for the tx encoder and the channel-side decoder.
// Latency: n/a (types, constants, pure functions only).
// Backpressure: n/a.
//
// Contents:
//   HAM_K / HAM_N       data and codeword widths
//   HAM_LAST            index of the last codeword bit (serializer terminal count)
//   ham_data_t          4-bit data nibble d[3:0]
//   ham_cw_t            7-bit codeword c[6:0], c[3:0] = data, c[6:4] = parity
//   tx_state_e          serializer FSM states
//   ham_encode()        nibble -> codeword
//   ham_bit_at()        pick the codeword bit sent at serial slot idx
package hamming_pkg;

    localparam int HAM_K = 4;
    localparam int HAM_N = 7;

    // Serial slot of the final codeword bit; the serializer reloads or idles here.
    localparam logic [2:0] HAM_LAST = 3'd6;

    typedef logic [HAM_K-1:0] ham_data_t;
    typedef logic [HAM_N-1:0] ham_cw_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } tx_state_e;

    // Systematic generator: the data nibble sits in c[3:0] unchanged, and each
    // parity bit covers a distinct three-bit subset of the data. The decoder
    // builds its syndrome from the same subsets, so both must come from here.
    function automatic ham_cw_t ham_encode(input ham_data_t d);
        ham_cw_t c;
        c[3:0] = d;
        c[4]   = d[0] ^ d[1] ^ d[2];
        c[5]   = d[0] ^ d[2] ^ d[3];
        c[6]   = d[0] ^ d[1] ^ d[3];
        return c;
    endfunction

    // Serial slot idx carries bit idx (LSB first) or bit 6-idx (MSB first).
    // idx never exceeds HAM_LAST, so the subtraction cannot wrap.
    function automatic logic ham_bit_at(input ham_cw_t   w,
                                        input logic [2:0] idx,
                                        input bit         msb_first);
        logic [2:0] pos;
        pos = msb_first ? (HAM_LAST - idx) : idx;
        return w[pos];
    endfunction

endpackage

// File: rtl/hamming_encode_core.sv
// Combinational (7,4) Hamming encoder: one data nibble in, one codeword out.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the result is captured.
//
// Ports:
//   data_i  4-bit data nibble
//   cw_o    7-bit systematic codeword
module hamming_encode_core
    import hamming_pkg::*;
(
    input  ham_data_t data_i,
    output ham_cw_t   cw_o
);

    assign cw_o = ham_encode(data_i);

endmodule

// File: rtl/hamming_encode_tx.sv
// Streaming (7,4) Hamming encoder + serializer with start-of-frame marker.
// Latency: handshake at edge N -> first codeword bit (with sof_o) after edge N.
// Backpressure: in_ready high in IDLE and on the last bit slot, so codewords run back-to-back.
//
// Build option: HAMMING_ERR_INJECT_EN adds inj_en/inj_pos, which flip one
// transmitted bit of the codeword (cw_o keeps the clean value).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready nibble handshake; in_data sampled only on handshake
//   in_data           data nibble
//   inj_en, inj_pos   (HAMMING_ERR_INJECT_EN only) bit-flip request, sampled on handshake
//   bit_o             serial channel bit
//   bit_valid_o       bit_o carries a codeword bit
//   sof_o             marks the first bit of each codeword
//   cw_o              clean codeword of the frame being sent, held until next acceptance
//   busy_o            serializer is shifting
// Parameter:
//   MSB_FIRST         0 = codeword bit 0 first, 1 = bit 6 first
module hamming_encode_tx
    import hamming_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
`ifdef HAMMING_ERR_INJECT_EN
    input  logic       inj_en,
    input  logic [2:0] inj_pos,
`endif
    output logic       bit_o,
    output logic       bit_valid_o,
    output logic       sof_o,
    output logic [6:0] cw_o,
    output logic       busy_o
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    tx_state_e  state_q;
    logic [2:0] cnt_q;      // serial slot currently on bit_o
    logic [2:0] cnt_d;
    ham_cw_t    tx_q;       // word actually transmitted (may carry an injected flip)
    ham_cw_t    cw_q;       // clean codeword for cw_o
    logic       bit_q;
    logic       bit_valid_q;
    logic       sof_q;
    logic       busy_q;

    // ------------------------------------------------------------------
    // Encode and optional error injection
    // ------------------------------------------------------------------
    ham_cw_t enc_cw;
    ham_cw_t flip_mask;
    ham_cw_t tx_load;
    logic    hs;

    hamming_encode_core u_core (
        .data_i (in_data),
        .cw_o   (enc_cw)
    );

`ifdef HAMMING_ERR_INJECT_EN
    // inj_pos == 7 has no codeword bit behind it and is the explicit "no flip" code.
    always_comb begin
        flip_mask = '0;
        if (inj_en && (inj_pos != 3'd7)) begin
            flip_mask = ham_cw_t'(7'd1 << inj_pos);
        end
    end
`else
    assign flip_mask = '0;
`endif

    assign tx_load = enc_cw ^ flip_mask;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // Ready depends only on registered state, never on in_valid, so the
    // upstream can build its valid from our ready without a loop. Opening
    // on the last slot is what allows gap-free back-to-back frames.
    assign in_ready = (state_q == ST_IDLE) ||
                      ((state_q == ST_SHIFT) && (cnt_q == HAM_LAST));

    assign hs    = in_valid && in_ready;
    assign cnt_d = cnt_q + 3'd1;

    // ------------------------------------------------------------------
    // FSM + serializer (all outputs registered)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            tx_q        <= '0;
            cw_q        <= '0;
            bit_q       <= 1'b0;
            bit_valid_q <= 1'b0;
            sof_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else if (hs) begin
            // Fresh frame, from IDLE or chained onto the last slot of the
            // previous one: slot 0 goes straight out next cycle.
            state_q     <= ST_SHIFT;
            cnt_q       <= 3'd0;
            tx_q        <= tx_load;
            cw_q        <= enc_cw;
            bit_q       <= ham_bit_at(tx_load, 3'd0, MSB_FIRST);
            bit_valid_q <= 1'b1;
            sof_q       <= 1'b1;
            busy_q      <= 1'b1;
        end else if ((state_q == ST_SHIFT) && (cnt_q != HAM_LAST)) begin
            cnt_q       <= cnt_d;
            bit_q       <= ham_bit_at(tx_q, cnt_d, MSB_FIRST);
            bit_valid_q <= 1'b1;
            sof_q       <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            // Idle, or last slot with nothing offered: drop to IDLE. cw_q is
            // deliberately held so cw_o shows the last frame until the next one.
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            bit_q       <= 1'b0;
            bit_valid_q <= 1'b0;
            sof_q       <= 1'b0;
            busy_q      <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bit_o       = bit_q;
    assign bit_valid_o = bit_valid_q;
    assign sof_o       = sof_q;
    assign cw_o        = cw_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_hamming_encode_tx.sv
// Self-checking bench for hamming_encode_tx (LSB-first and MSB-first instances).
// Latency: n/a (testbench).
// Backpressure: stimulus waits on in_ready with a bounded cycle budget.
module tb_hamming_encode_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'd0;
    logic       inj_en = 1'b0;
    logic [2:0] inj_pos = 3'd7;

    logic       in_ready0, bit0, vld0, sof0, busy0;
    logic [6:0] cw0;
    logic       in_ready1, bit1, vld1, sof1, busy1;
    logic [6:0] cw1;

    always #5 clk = ~clk;

    hamming_encode_tx #(.MSB_FIRST(1'b0)) dut0 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready0),
        .in_data     (in_data),
`ifdef HAMMING_ERR_INJECT_EN
        .inj_en      (inj_en),
        .inj_pos     (inj_pos),
`endif
        .bit_o       (bit0),
        .bit_valid_o (vld0),
        .sof_o       (sof0),
        .cw_o        (cw0),
        .busy_o      (busy0)
    );

    hamming_encode_tx #(.MSB_FIRST(1'b1)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready1),
        .in_data     (in_data),
`ifdef HAMMING_ERR_INJECT_EN
        .inj_en      (inj_en),
        .inj_pos     (inj_pos),
`endif
        .bit_o       (bit1),
        .bit_valid_o (vld1),
        .sof_o       (sof1),
        .cw_o        (cw1),
        .busy_o      (busy1)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Parity bits as masked reductions over the nibble.
    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] c;
        c[3:0] = d;
        c[4]   = ^(d & 4'b0111);
        c[5]   = ^(d & 4'b1101);
        c[6]   = ^(d & 4'b1011);
        return c;
    endfunction

    function automatic logic [2:0] syn(input logic [6:0] c);
        return {c[6] ^ c[0] ^ c[1] ^ c[3],
                c[5] ^ c[0] ^ c[2] ^ c[3],
                c[4] ^ c[0] ^ c[1] ^ c[2]};
    endfunction

    // Single-error-correcting decode: flip the position whose column matches the syndrome.
    function automatic logic [3:0] dec(input logic [6:0] c);
        logic [6:0] r;
        logic [6:0] u;
        r = c;
        if (syn(c) != 3'd0) begin
            for (int j = 0; j < 7; j++) begin
                u = 7'd1 << j;
                if (syn(u) == syn(c)) r[j] = ~r[j];
            end
        end
        return r[3:0];
    endfunction

    // Queue of serial slots still to be sent after the current one.
    int         q_k[$];
    logic [6:0] q_tx[$];
    logic       m_vld = 1'b0;
    logic       m_sof = 1'b0;
    int         m_k = 0;
    logic [6:0] m_tx = 7'd0;
    logic [6:0] m_cw = 7'd0;

    initial begin : model
        logic       rdy;
        logic [6:0] c;
        logic [6:0] t;
        forever begin
            @(posedge clk);
            rdy = (q_k.size() == 0);
            if (rst) begin
                q_k.delete(); q_tx.delete();
                m_vld = 1'b0; m_sof = 1'b0; m_k = 0; m_tx = 7'd0; m_cw = 7'd0;
            end else begin
                if (in_valid && rdy) begin
                    c = enc(in_data);
                    t = c;
`ifdef HAMMING_ERR_INJECT_EN
                    if (inj_en && inj_pos != 3'd7) t[inj_pos] = ~t[inj_pos];
`endif
                    m_cw = c;
                    for (int k = 0; k < 7; k++) begin
                        q_k.push_back(k);
                        q_tx.push_back(t);
                    end
                end
                if (q_k.size() > 0) begin
                    m_k = q_k.pop_front(); m_tx = q_tx.pop_front();
                    m_vld = 1'b1; m_sof = (m_k == 0);
                end else begin
                    m_vld = 1'b0; m_sof = 1'b0;
                end
            end
        end
    end

    // ---------------- compare + stream capture ----------------
    bit         armed = 1'b0;
    logic [6:0] done0[$];
    logic [6:0] done1[$];
    int         sof_cyc[$];
    int         max_run = 0;

    initial begin : compare
        int cyc = 0, run = 0, k0 = 0, k1 = 0;
        logic [6:0] w0 = 7'd0;
        logic [6:0] s1 = 7'd0;
        forever begin
            @(negedge clk);
            cyc++;
            if (armed) begin
                chk("in_ready0", in_ready0, q_k.size() == 0);
                chk("in_ready1", in_ready1, q_k.size() == 0);
                chk("bit_valid0", vld0, m_vld);
                chk("bit_valid1", vld1, m_vld);
                chk("sof0", sof0, m_sof);
                chk("sof1", sof1, m_sof);
                chk("busy0", busy0, m_vld);
                chk("cw0", cw0, m_cw);
                chk("cw1", cw1, m_cw);
                if (m_vld) begin
                    chk("bit0", bit0, m_tx[m_k]);
                    chk("bit1", bit1, m_tx[6 - m_k]);
                end
                if (vld0) begin
                    run++;
                    if (run > max_run) max_run = run;
                    if (sof0) begin k0 = 0; w0 = 7'd0; sof_cyc.push_back(cyc); end
                    w0[k0] = bit0;
                    k0++;
                    if (k0 == 7) done0.push_back(w0);
                end else begin
                    run = 0;
                end
                if (vld1) begin
                    if (sof1) begin k1 = 0; s1 = 7'd0; end
                    s1 = {s1[5:0], bit1};
                    k1++;
                    if (k1 == 7) done1.push_back(s1);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [3:0] d, input logic ie = 1'b0, input logic [2:0] ip = 3'd7);
        bit ok = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; inj_en = ie; inj_pos = ip;
        for (int i = 0; i < 30 && !ok; i++) begin
            if (i > 0) @(negedge clk);
            ok = in_ready0;
            @(posedge clk);
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pop_word(input bit msb, input string nm, input logic [6:0] exp);
        if (msb) begin
            if (done1.size() == 0) chk({nm, "_missing"}, 32'd0, 32'd1);
            else chk(nm, done1.pop_front(), exp);
        end else begin
            if (done0.size() == 0) chk({nm, "_missing"}, 32'd0, 32'd1);
            else chk(nm, done0.pop_front(), exp);
        end
    endtask

    initial begin : stim
        logic [6:0] w;
        repeat (2) @(posedge clk);
        @(negedge clk);
        // Reset values (rst still high)
        chk("rst_in_ready", in_ready0, 1);
        chk("rst_bit_valid", vld0, 0);
        chk("rst_sof", sof0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_cw", cw0, 7'h00);
        chk("rst_bit", bit0, 0);
        rst = 1'b0;
        armed = 1'b1;

        // Single word, LSB first: 0001 -> 0x71, serial 1,0,0,0,1,1,1
        send(4'b0001);
        idle(9);
        pop_word(1'b0, "single_lsb", 7'h71);
        chk("single_cw", cw0, 7'h71);
        chk("single_idle_vld", vld0, 0);
        chk("single_idle_rdy", in_ready0, 1);
        done1.delete();

        // Back-to-back, in_valid held across the chain
        sof_cyc.delete(); max_run = 0;
        send(4'b1011);
        send(4'b1111);
        idle(16);
        chk("b2b_words", done0.size(), 2);
        pop_word(1'b0, "b2b_w0", 7'h4B);
        pop_word(1'b0, "b2b_w1", 7'h7F);
        pop_word(1'b1, "msb_1011", 7'h4B);   // serial order 1,0,0,1,0,1,1
        pop_word(1'b1, "msb_1111", 7'h7F);
        chk("b2b_run", max_run, 14);
        chk("b2b_sofs", sof_cyc.size(), 2);
        if (sof_cyc.size() == 2) chk("b2b_sof_gap", sof_cyc[1] - sof_cyc[0], 7);

        // Reset mid-codeword after the third bit
        done0.delete(); done1.delete();
        send(4'b0001);
        @(negedge clk);          // bit 0
        @(negedge clk);          // bit 1
        @(negedge clk);          // bit 2
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_vld", vld0, 0);
        chk("mid_rst_sof", sof0, 0);
        chk("mid_rst_busy", busy0, 0);
        chk("mid_rst_bit", bit0, 0);
        chk("mid_rst_cw", cw0, 7'h00);
        chk("mid_rst_rdy", in_ready0, 1);
        rst = 1'b0;
        idle(2);
        chk("mid_rst_no_resume", done0.size(), 0);
        sof_cyc.delete();
        send(4'b0000);
        idle(9);
        chk("after_rst_words", done0.size(), 1);
        pop_word(1'b0, "after_rst_zero", 7'h00);
        chk("after_rst_sof", sof_cyc.size(), 1);

        // in_data toggling while not ready has no effect
        done0.delete(); done1.delete();
        send(4'b1010);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data = (i % 2 == 0) ? 4'b0101 : 4'b1111;
            chk("stable_cw", cw0, 7'h3A);
        end
        idle(4);
        pop_word(1'b0, "stable_word", 7'h3A);

`ifdef HAMMING_ERR_INJECT_EN
        done0.delete(); done1.delete();
        send(4'b0001, 1'b1, 3'd2);
        idle(9);
        chk("inj_cw", cw0, 7'h71);
        if (done0.size() == 0) chk("inj_missing", 32'd0, 32'd1);
        else begin
            w = done0.pop_front();
            chk("inj_stream", w, 7'h75);
            chk("inj_decode", dec(w), 4'b0001);
        end
        send(4'b0001, 1'b1, 3'd7);
        idle(9);
        pop_word(1'b0, "inj_pos7", 7'h71);
`else
        w = 7'h75;
        chk("decode_pin", dec(w), 4'b0001);
`endif

        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "timeout");
    end

endmodule
